sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-ported external SRAM between the instruction-fetch stage (read-only) and the MEM stage (LD/ST, driven by the control unit's mem_r_en/mem_w_en).
- Sequences each fixed-latency SRAM access.
- Raises freeze to stall the pipeline while a MEM-stage access is outstanding.
- Sits between the IF/MEM stages and the SRAM pins.

Parameters:
- ADDR_W, 32, address width of both requesters and SRAM.
- DATA_W, 32, data width.
- WAIT_CYCLES, 4, SRAM access duration in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; registered, valid with if_ready, held afterwards.
- if_ready  out  1  one-cycle pulse: fetch access complete.
- mem_r_en  in  1  MEM-stage load request.
- mem_w_en  in  1  MEM-stage store request.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load result; registered, valid with mem_ready, held afterwards.
- mem_ready  out  1  one-cycle pulse: MEM access complete.
- freeze  out  1  pipeline stall.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid in the last ACCESS cycle.
- sram_we  out  1  SRAM write strobe.
- sram_rd  out  1  SRAM read strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, last_owner=IF.
  - All outputs 0, including if_rdata and mem_rdata.
  - Takes effect immediately, even mid-ACCESS: sram_we/sram_rd drop with no clock edge; an in-flight store is abandoned and no ready pulse is produced.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Sample requests at each edge.
  - MEM request = mem_r_en|mem_w_en; if both enables are high, treat as a store.
  - Only one requester active: grant it.
  - Both active: grant the requester not equal to last_owner (round-robin), so MEM wins the first tie after reset.
  - On grant: latch owner, address, wdata and op; counter=WAIT_CYCLES-1; go to ACCESS; last_owner=owner.
- ACCESS:
  - Drive sram_addr/sram_wdata from the latched values.
  - Store: sram_we=1 in every ACCESS cycle. Read: sram_rd=1 in every ACCESS cycle.
  - Decrement counter each cycle.
  - On the counter==0 edge: for reads, capture sram_rdata into the owner's rdata register; go to DONE.
- DONE:
  - Assert the owner's ready for exactly one cycle; SRAM strobes 0; go to IDLE.
  - A new grant is possible on the DONE->IDLE edge +1, i.e. the first IDLE cycle samples requests.
- Latency: request first sampled at edge 0 -> ACCESS cycles 1..WAIT_CYCLES -> ready high in cycle WAIT_CYCLES+1.
  - Back-to-back accesses: one request every WAIT_CYCLES+2 cycles.
- freeze (combinational) = (mem_r_en|mem_w_en) & ~mem_ready.
  - Stays high while the MEM request waits for arbitration or access, including while a fetch owns the SRAM.
  - Falls in the mem_ready cycle.
- Latched address and data are stable for the whole access; input changes during ACCESS are ignored.
- Requester drops its request mid-access: the access still completes and the ready pulse is still issued.
- sram_addr/sram_wdata are 0 when not in ACCESS.
- rdata registers change only on a completed read of their own port; stores never modify mem_rdata.

Test Plan:
- Reset, then fetch if_addr=0x40, sram_rdata=0xDEADBEEF -> sram_rd high cycles 1-4, if_ready pulse in cycle 5, if_rdata=0xDEADBEEF; freeze stays 0.
- Store mem_w_en=1, mem_addr=0x100, mem_wdata=0x1234 -> sram_we high for 4 cycles with sram_addr=0x100 and sram_wdata=0x1234; freeze=1 in cycles 0-4, 0 in cycle 5 with mem_ready=1; mem_rdata unchanged.
- if_req and mem_r_en asserted together right after reset -> MEM granted first; fetch granted in the following IDLE cycle; if_ready arrives 6 cycles after mem_ready.
- Both requesters held continuously for 4 accesses -> grant order MEM, IF, MEM, IF; each ready pulse is exactly 1 cycle wide; spacing is 6 cycles.
- mem_r_en and mem_w_en both high -> store performed (sram_we=1, sram_rd=0).
- rst asserted in the 2nd ACCESS cycle of a store -> sram_we=0 immediately with no clock edge; no ready pulse; after release, state is IDLE and the next tie goes to MEM.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-ported SRAM between instruction fetch and the MEM stage.
// Each access runs a fixed WAIT_CYCLES window, then a one-cycle ready pulse.
module sram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_we,
  output logic              sram_rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic              owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
  logic              mem_req;
  logic              grant_mem;
  logic              in_access;

  assign mem_req = mem_r_en | mem_w_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      owner_reg      <= OWN_IF;
      last_owner_reg <= OWN_IF;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      write_reg      <= write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      if_rdata_reg   <= if_rdata_next;
      mem_rdata_reg  <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    write_next      = write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    if_rdata_next   = if_rdata_reg;
    mem_rdata_next  = mem_rdata_reg;
    grant_mem       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req || mem_req) begin
          // On a tie the port that did not own the previous access wins.
          grant_mem       = mem_req && (!if_req || last_owner_reg == OWN_IF);
          owner_next      = grant_mem;
          last_owner_next = grant_mem;
          addr_next       = grant_mem ? mem_addr : if_addr;
          wdata_next      = grant_mem ? mem_wdata : '0;
          write_next      = grant_mem & mem_w_en;
          count_next      = CNT_LOAD;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (count_reg == 4'd0) begin
          state_next = DONE;
          if (!write_reg) begin
            if (owner_reg == OWN_IF) if_rdata_next  = sram_rdata;
            else                     mem_rdata_next = sram_rdata;
          end
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_access  = (state_reg == ACCESS);
  assign sram_we    = in_access & write_reg;
  assign sram_rd    = in_access & ~write_reg;
  assign sram_addr  = in_access ? addr_reg : '0;
  assign sram_wdata = in_access ? wdata_reg : '0;
  assign if_ready   = (state_reg == DONE) && (owner_reg == OWN_IF);
  assign mem_ready  = (state_reg == DONE) && (owner_reg != OWN_IF);
  assign freeze     = mem_req & ~mem_ready;
  assign busy       = (state_reg != IDLE);
  assign if_rdata   = if_rdata_reg;
  assign mem_rdata  = mem_rdata_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: drivers queue expected accesses,
// a negedge monitor checks SRAM pin activity and ready/rdata as they appear.
module tb_sram_port_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int W      = 4;
  localparam int N_RAND = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_r_en = 1'b0;
  logic          mem_w_en = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          freeze;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          sram_we;
  logic          sram_rd;
  logic          busy;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we(sram_we), .sram_rd(sram_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  typedef struct {
    bit is_mem;
    int cyc;
  } done_t;

  txn_t  if_q[$];
  txn_t  mem_q[$];
  done_t done_log[$];

  logic [DW-1:0] ref_mem    [logic [AW-1:0]];
  logic [DW-1:0] sram_cells [logic [AW-1:0]];
  logic [DW-1:0] exp_if_rdata  = '0;
  logic [DW-1:0] exp_mem_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  int            run_len = 0;
  logic [AW-1:0] run_addr = '0;
  logic [DW-1:0] run_wdata = '0;
  logic          run_we = 1'b0;
  bit            run_stable = 1'b1;
  logic          prev_if_ready = 1'b0;
  logic          prev_mem_ready = 1'b0;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_run(input txn_t t, input string port);
    check({port, "_strobe_cycles"}, run_len, W);
    check({port, "_pins_stable"}, run_stable, 1);
    check({port, "_op"}, run_we, t.write);
    check({port, "_sram_addr"}, run_addr, t.addr);
    if (t.write) check({port, "_sram_wdata"}, run_wdata, t.wdata);
    run_len = 0;
  endtask

  task automatic monitor_step();
    txn_t t;
    done_t d;
    check("freeze", freeze, (mem_r_en | mem_w_en) & ~mem_ready);
    check("strobe_exclusive", sram_we & sram_rd, 0);
    if (sram_we | sram_rd) begin
      if (run_len == 0) begin
        run_addr = sram_addr; run_wdata = sram_wdata; run_we = sram_we; run_stable = 1'b1;
      end else if (sram_addr !== run_addr || sram_wdata !== run_wdata || sram_we !== run_we) begin
        run_stable = 1'b0;
      end
      run_len++;
    end else begin
      check("idle_pins_zero", {sram_addr, sram_wdata}, 64'h0);
    end
    if (if_ready) begin
      check("if_pulse_width", prev_if_ready, 0);
      check("ready_exclusive", mem_ready, 0);
      check("if_expected", if_q.size() != 0, 1);
      if (if_q.size() != 0) begin
        t = if_q.pop_front();
        exp_if_rdata = t.rdata;
        compare_run(t, "if");
        d.is_mem = 1'b0; d.cyc = cyc; done_log.push_back(d);
        $display("txn IF  rd addr=%h rdata=%h cyc=%0d", t.addr, if_rdata, cyc);
      end
    end
    if (mem_ready) begin
      check("mem_pulse_width", prev_mem_ready, 0);
      check("mem_expected", mem_q.size() != 0, 1);
      if (mem_q.size() != 0) begin
        t = mem_q.pop_front();
        if (!t.write) exp_mem_rdata = t.rdata;
        compare_run(t, "mem");
        d.is_mem = 1'b1; d.cyc = cyc; done_log.push_back(d);
        $display("txn MEM %s addr=%h wdata=%h rdata=%h cyc=%0d",
                 t.write ? "wr" : "rd", t.addr, t.wdata, mem_rdata, cyc);
      end
    end
    check("if_rdata", if_rdata, exp_if_rdata);
    check("mem_rdata", mem_rdata, exp_mem_rdata);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM pin model plus monitor, both evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (sram_we) sram_cells[sram_addr] = sram_wdata;
    sram_rdata = sram_cells.exists(sram_addr) ? sram_cells[sram_addr] : pattern(sram_addr);
    if (mon_en) monitor_step();
    prev_if_ready  = if_ready;
    prev_mem_ready = mem_ready;
  end

  task automatic if_access(input logic [AW-1:0] a, output int lat);
    txn_t t;
    int   start;
    bit   seen;
    t.write = 1'b0; t.addr = a; t.wdata = '0; t.rdata = ref_read(a);
    if_q.push_back(t);
    if_addr = a; if_req = 1'b1;
    start = cyc; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_ready) begin seen = 1'b1; break; end
    end
    lat = cyc - start;
    check("if_done_in_time", seen, 1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = $urandom;
  endtask

  task automatic mem_access(input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int lat);
    txn_t t;
    int   start;
    bit   seen;
    t.write = wr; t.addr = a; t.wdata = d;
    t.rdata = wr ? '0 : ref_read(a);
    if (wr) ref_mem[a] = d;
    mem_q.push_back(t);
    mem_addr = a; mem_wdata = d; mem_r_en = rd; mem_w_en = wr;
    start = cyc; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_ready) begin seen = 1'b1; break; end
    end
    lat = cyc - start;
    check("mem_done_in_time", seen, 1);
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0;
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_strobes", {sram_we, sram_rd}, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_freeze", freeze, 0);
    if_q.delete(); mem_q.delete(); done_log.delete();
    exp_if_rdata = '0; exp_mem_rdata = '0; run_len = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_a, lat_b, lat_c, lat_d;
    int g_if, g_mem, op;
    logic [AW-1:0] a_if, a_mem;
    logic [DW-1:0] d_mem;

    do_reset();

    // Plain fetch and plain store, uncontended.
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    sram_cells[32'h40] = 32'hDEAD_BEEF;
    if_access(32'h40, lat_a);
    check("t1_latency", lat_a, W + 1);
    check("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
    mem_access(1'b0, 1'b1, 32'h100, 32'h1234, lat_a);
    check("t2_latency", lat_a, W + 1);
    check("t2_mem_rdata_untouched", mem_rdata, 32'h0);

    // Tie right after reset: MEM first, fetch one access later.
    do_reset();
    fork
      if_access(32'h80, lat_a);
      mem_access(1'b1, 1'b0, 32'h100, 32'h0, lat_b);
    join
    check("t3_mem_latency", lat_b, W + 1);
    check("t3_if_latency", lat_a, 2 * W + 3);
    check("t3_mem_rdata", mem_rdata, 32'h1234);
    check("t3_log_len", done_log.size(), 2);
    if (done_log.size() >= 2) begin
      check("t3_first_is_mem", done_log[0].is_mem, 1);
      check("t3_second_is_if", done_log[1].is_mem, 0);
      check("t3_spacing", done_log[1].cyc - done_log[0].cyc, W + 2);
    end

    // Both held continuously: strict alternation at W+2 spacing.
    done_log.delete();
    fork
      begin
        mem_access(1'b1, 1'b0, 32'h100, 32'h0, lat_c);
        mem_access(1'b0, 1'b1, 32'h1004, 32'h5555_AAAA, lat_c);
      end
      begin
        if_access(32'h84, lat_d);
        if_access(32'h88, lat_d);
      end
    join
    check("t4_log_len", done_log.size(), 4);
    if (done_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t4_grant_order", done_log[i].is_mem, (i % 2 == 0) ? 1 : 0);
        if (i > 0) check("t4_spacing", done_log[i].cyc - done_log[i-1].cyc, W + 2);
      end
    end

    // Both enables high behaves as a store; read it back.
    mem_access(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, lat_a);
    mem_access(1'b1, 1'b0, 32'h104, 32'h0, lat_a);
    check("t5_readback", mem_rdata, 32'hCAFE_F00D);

    // Reset during the second ACCESS cycle of a store.
    mem_addr = 32'h2000; mem_wdata = 32'h7777_0001; mem_w_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t6_we_before_reset", sram_we, 1);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_we_async_drop", sram_we, 0);
    check("t6_busy_async_drop", busy, 0);
    check("t6_addr_async_drop", sram_addr, 0);
    check("t6_no_ready", mem_ready, 0);
    mem_w_en = 1'b0;
    do_reset();
    fork
      if_access(32'h8C, lat_a);
      mem_access(1'b1, 1'b0, 32'h104, 32'h0, lat_b);
    join
    check("t6_log_len", done_log.size(), 2);
    if (done_log.size() >= 2) check("t6_tie_to_mem", done_log[0].is_mem, 1);

    // Randomised concurrent traffic from both ports.
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          g_if = $urandom_range(0, 3);
          repeat (g_if) @(posedge clk);
          if (g_if > 0) #1;
          a_if = {20'h0, 10'($urandom), 2'b00};
          if_access(a_if, lat_c);
          check("if_latency_bound", (lat_c >= W + 1) && (lat_c <= 2 * W + 3), 1);
        end
      end
      begin
        for (int i = 0; i < N_RAND; i++) begin
          g_mem = $urandom_range(0, 3);
          repeat (g_mem) @(posedge clk);
          if (g_mem > 0) #1;
          a_mem = 32'h1000 | {26'h0, 4'($urandom), 2'b00};
          d_mem = $urandom;
          op = $urandom_range(0, 2);
          mem_access(op != 1, op != 0, a_mem, d_mem, lat_d);
          check("mem_latency_bound", (lat_d >= W + 1) && (lat_d <= 2 * W + 3), 1);
        end
      end
    join

    repeat (4) @(posedge clk);
    #1;
    check("if_q_drained", if_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    check("idle_at_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
